fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
- Drain stage directly downstream of the 16-entry 8-bit FIFO.
- Watches the FIFO's empty flag and issues single-cycle pop pulses.
- Captures the byte the FIFO registers onto its data output one cycle after each pop.
- Serialises each byte as a UART 8N1 frame on tx; targets the 100 MHz Artix-7 board clock.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2; baud counter width = $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
tx_en  input  1  enables draining; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_data  input  8  FIFO registered read data (valid the cycle after pop is sampled)
fifo_pop  output  1  pop request to FIFO, registered, one-cycle pulse
tx  output  1  UART serial line, idle high
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse at end of stop bit

Behaviour:
- Reset (async, immediate): state=IDLE, tx=1, fifo_pop=0, busy=0, frame_done=0, shift register=0, baud and bit counters=0.
- States: IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
- IDLE, edge E0, if tx_en && !fifo_empty: fifo_pop<=1, go to POP. Otherwise remain, tx=1.
- POP, edge E1: fifo_pop<=0, go to LOAD. The FIFO samples the pop at this same edge and updates fifo_data.
- LOAD, edge E2: shreg<=fifo_data, tx<=0, baud counter cleared, go to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit index counter 0..7; shift right on each bit boundary.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, frame_done<=1 for one cycle and go to IDLE.
- fifo_pop never asserts outside the IDLE->POP transition; at most one pop per frame, so FIFO underflow is impossible by construction.
- Timing:
  - tx falls 2 cycles after the IDLE sampling edge.
  - Back-to-back frame period (tx falling edge to next tx falling edge) = 10*CLKS_PER_BIT + 3 cycles with the FIFO continuously non-empty.
- tx_en deasserted mid-frame: current frame completes normally; no further pops.
- fifo_empty changes outside IDLE: ignored.
- tx, fifo_pop and frame_done are driven directly from flops; no combinational paths to outputs except busy (state decode).
- Reset mid-frame: tx returns high immediately, no frame_done. A byte already popped is discarded (accepted loss).

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP; tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11 bits; back-to-back period = 11*CLKS_PER_BIT + 3.
- Undefined: no PARITY state or parity logic synthesised; 8N1 only.

Test Plan:
All scenarios use CLKS_PER_BIT=4, with the block connected to the real 16-entry FIFO upstream.
1. Assert rst for 3 cycles then release, tx_en=1, FIFO empty -> tx=1, fifo_pop=0, busy=0, frame_done=0 throughout; no pop while empty.
2. Push 0xA5, tx_en=1 -> exactly one fifo_pop pulse; 2 cycles after the IDLE sampling edge tx drives 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 4 cycles; frame_done pulses once, 40 cycles after tx fell; FIFO error never asserts.
3. Push 0x00, 0xFF, 0x3C back-to-back -> three frames decoded in order 0x00, 0xFF, 0x3C; tx falling edges spaced 43 cycles apart; three frame_done pulses; FIFO empty after the third pop.
4. FIFO holds 2 bytes, tx_en=0 -> no pop, tx=1. Then tx_en=1 for one cycle only -> exactly one frame sent, one byte left in the FIFO.
5. rst asserted during data bit 3 of a frame -> tx=1 in the same cycle (async), busy=0, no frame_done. After release, the next pushed byte 0x81 is transmitted cleanly.
6. With FIFO_UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1 between bit 7 and stop; frame spacing 47 cycles. Send 0x03 -> parity bit=0.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO-drain / UART-line signal bundle for fifo_uart_tx.
// master = the transmitter, slave = the FIFO plus line consumer.
interface fifo_uart_tx_if;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    input  tx_en, fifo_empty, fifo_data,
    output fifo_pop, tx, busy, frame_done
  );

  modport slave (
    output tx_en, fifo_empty, fifo_data,
    input  fifo_pop, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from an upstream registered-output FIFO and sends them as UART 8N1 frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input logic            clk,
  input logic            rst,
  fifo_uart_tx_if.master bus
);

  localparam int unsigned    CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tx_q;
  logic          pop_q;
  logic          done_q;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          parity_q;
`endif

  wire baud_last = (baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      pop_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      pop_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (bus.tx_en && !bus.fifo_empty) begin
            pop_q <= 1'b1;
            state <= S_POP;
          end
        end
        // FIFO samples the pop on this edge; its data is valid at the next one
        S_POP: state <= S_LOAD;
        S_LOAD: begin
          shreg    <= bus.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q <= ^bus.fifo_data;
`endif
          tx_q     <= 1'b0;
          baud     <= '0;
          bit_cnt  <= '0;
          state    <= S_START;
        end
        S_START: begin
          if (baud_last) begin
            baud  <= '0;
            tx_q  <= shreg[0];
            state <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        // tx is loaded one bit ahead (shreg[1]) because the shift lands on the same edge
        S_DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx_q  <= parity_q;
              state <= S_PARITY;
`else
              tx_q  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            baud  <= '0;
            tx_q  <= 1'b1;
            state <= S_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_last) begin
            baud   <= '0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.fifo_pop   = pop_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = (state != S_IDLE);

endmodule
